// File: rtl/sb_config_sequencer_pkg.sv
// Shared types and constants for the switch box configuration sequencer.
package sb_cfg_pkg;

   localparam int unsigned SB_CFG_W = 12;
   localparam int unsigned SB_GRP_W = 4;

   // Enable-group bit positions within one element's c[11:0]
   localparam int unsigned SB_TURN_LSB     = 0;
   localparam int unsigned SB_STRAIGHT_LSB = 4;
   localparam int unsigned SB_CROSS_LSB    = 8;

   typedef enum logic {
      IDLE  = 1'b0,
      BREAK = 1'b1
   } sb_state_e;

endpackage

// File: rtl/sb_config_sequencer_if.sv
// Config write port: valid/ready handshake carrying element address and pattern.
interface sb_config_sequencer_if #(
   parameter int unsigned ADDR_W = 6
);
   import sb_cfg_pkg::*;

   logic                cfg_valid;
   logic                cfg_ready;
   logic [ADDR_W-1:0]   cfg_addr;
   logic [SB_CFG_W-1:0] cfg_data;

   modport master (output cfg_valid, output cfg_addr, output cfg_data, input cfg_ready);
   modport slave  (input cfg_valid, input cfg_addr, input cfg_data, output cfg_ready);

endinterface

// File: rtl/sb_cfg_slot.sv
// One switch box element: shadow pattern, live enables and pending-change flag.
module sb_cfg_slot
   import sb_cfg_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                wr_en,
   input  logic [SB_CFG_W-1:0] wr_data,
   input  logic                break_en,
   input  logic                apply_en,
   input  logic                clear,
   output logic [SB_CFG_W-1:0] c,
   output logic                dirty
);

   logic [SB_CFG_W-1:0] shadow_q;

   // A write landing with the commit counts as dirty, so it is opened too
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         shadow_q <= '0;
         c        <= '0;
         dirty    <= 1'b0;
      end else if (clear) begin
         shadow_q <= '0;
         c        <= '0;
         dirty    <= 1'b0;
      end else begin
         if (wr_en) begin
            shadow_q <= wr_data;
            dirty    <= 1'b1;
         end
         if (break_en && (dirty || wr_en)) begin
            c <= '0;
         end else if (apply_en && dirty) begin
            c     <= shadow_q;
            dirty <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/sb_config_sequencer.sv
// Break-before-make configuration sequencer for NUM_SB switch box elements.
module sb_config_sequencer
   import sb_cfg_pkg::*;
#(
   parameter int unsigned NUM_SB       = 4,
   parameter int unsigned ADDR_W       = 6,
   parameter int unsigned BREAK_CYCLES = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   sb_config_sequencer_if.slave       cfg,
   input  logic                       commit_req,
   input  logic                       clear_req,
   output logic                       busy,
   output logic                       commit_done,
   output logic                       err_addr,
   output logic [SB_CFG_W*NUM_SB-1:0] sb_c
);

   localparam int unsigned CNT_W = $clog2(BREAK_CYCLES) + 1;
   localparam logic [ADDR_W:0] NUM_SB_L = (ADDR_W + 1)'(NUM_SB);

   sb_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [NUM_SB-1:0] dirty;
   logic              idle, in_range, wr_ok, any_dirty;
   logic              break_en, apply_en, clear_all, done_d, err_d;

   assign idle          = (state_q == IDLE);
   assign cfg.cfg_ready = idle;
   assign busy          = !idle;
   assign in_range      = ({1'b0, cfg.cfg_addr} < NUM_SB_L);
   assign wr_ok         = cfg.cfg_valid && idle && !clear_req && in_range;
   assign any_dirty     = (|dirty) || wr_ok;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         commit_done <= 1'b0;
         err_addr    <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         commit_done <= done_d;
         err_addr    <= err_d;
      end
   end

   // Next-state and per-cycle slot controls
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      break_en  = 1'b0;
      apply_en  = 1'b0;
      clear_all = 1'b0;
      done_d    = 1'b0;
      err_d     = cfg.cfg_valid && idle && !clear_req && !in_range;
      unique case (state_q)
         IDLE: begin
            if (clear_req) begin
               clear_all = 1'b1;
            end else if (commit_req) begin
               if (any_dirty) begin
                  state_d  = BREAK;
                  cnt_d    = CNT_W'(BREAK_CYCLES - 1);
                  break_en = 1'b1;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         BREAK: begin
            if (cnt_q == '0) begin
               apply_en = 1'b1;
               done_d   = 1'b1;
               state_d  = IDLE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   for (genvar k = 0; k < NUM_SB; k++) begin : g_slot
      sb_cfg_slot u_slot (
         .clk      (clk),
         .rst_n    (rst_n),
         .wr_en    (wr_ok && (cfg.cfg_addr == ADDR_W'(k))),
         .wr_data  (cfg.cfg_data),
         .break_en (break_en),
         .apply_en (apply_en),
         .clear    (clear_all),
         .c        (sb_c[SB_CFG_W*k +: SB_CFG_W]),
         .dirty    (dirty[k])
      );
   end

endmodule

// File: tb/tb_sb_config_sequencer.sv
// Directed bench for sb_config_sequencer with NUM_SB=4, BREAK_CYCLES=2.
module tb_sb_config_sequencer;
   import sb_cfg_pkg::*;

   localparam int unsigned NUM_SB = 4;
   localparam int unsigned ADDR_W = 6;
   localparam int unsigned BRK    = 2;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              commit_req, clear_req;
   logic              busy, commit_done, err_addr;
   logic [47:0]       sb_c;
   int                n_pass = 0;
   int                n_total = 0;

   sb_config_sequencer_if #(.ADDR_W(ADDR_W)) cfg_if ();

   sb_config_sequencer #(
      .NUM_SB(NUM_SB), .ADDR_W(ADDR_W), .BREAK_CYCLES(BRK)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cfg         (cfg_if),
      .commit_req  (commit_req),
      .clear_req   (clear_req),
      .busy        (busy),
      .commit_done (commit_done),
      .err_addr    (err_addr),
      .sb_c        (sb_c)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic wr(input logic [ADDR_W-1:0] a, input logic [11:0] d);
      cfg_if.cfg_valid = 1'b1;
      cfg_if.cfg_addr  = a;
      cfg_if.cfg_data  = d;
   endtask

   task automatic idle_in();
      cfg_if.cfg_valid = 1'b0;
      commit_req       = 1'b0;
      clear_req        = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      cfg_if.cfg_addr = '0;
      cfg_if.cfg_data = '0;
      idle_in();
      tick(); tick();
      chk("rst_sb_c", 64'(sb_c), 64'h0);
      chk("rst_busy", 64'(busy), 64'h0);
      chk("rst_done", 64'(commit_done), 64'h0);
      chk("rst_err", 64'(err_addr), 64'h0);
      chk("rst_ready", 64'(cfg_if.cfg_ready), 64'h1);

      // 1: single element commit
      rst_n = 1'b1;
      wr(6'd1, 12'h0F0); tick();
      idle_in(); commit_req = 1'b1; tick();
      commit_req = 1'b0;
      chk("t1_brk1_sb_c", 64'(sb_c), 64'h0);
      chk("t1_brk1_busy", 64'(busy), 64'h1);
      chk("t1_brk1_ready", 64'(cfg_if.cfg_ready), 64'h0);
      chk("t1_brk1_done", 64'(commit_done), 64'h0);
      tick();
      chk("t1_brk2_sb_c", 64'(sb_c), 64'h0);
      chk("t1_brk2_busy", 64'(busy), 64'h1);
      tick();
      chk("t1_live_sb_c", 64'(sb_c), 64'h0000_0000_00F0_0000 >> 4);
      chk("t1_live_done", 64'(commit_done), 64'h1);
      chk("t1_live_busy", 64'(busy), 64'h0);
      tick();
      chk("t1_done_pulse", 64'(commit_done), 64'h0);

      // 2: element 0 = 011, then change only element 2
      wr(6'd0, 12'h011); commit_req = 1'b1; tick();
      idle_in(); tick(); tick();
      chk("t2_e0_sb_c", 64'(sb_c), 64'h0000_0000_0F00_11);
      chk("t2_e0_done", 64'(commit_done), 64'h1);
      wr(6'd2, 12'h800); tick();
      idle_in(); commit_req = 1'b1; tick();
      commit_req = 1'b0;
      chk("t2_brk1_sb_c", 64'(sb_c), 64'h0000_0000_0F00_11);
      tick();
      chk("t2_brk2_sb_c", 64'(sb_c), 64'h0000_0000_0F00_11);
      tick();
      chk("t2_live_sb_c", 64'(sb_c), 64'h0000_8000_F001_1);
      chk("t2_live_done", 64'(commit_done), 64'h1);

      // 3: out-of-range write, then a commit with nothing dirty
      wr(6'd5, 12'h123); tick();
      chk("t3_err", 64'(err_addr), 64'h1);
      chk("t3_err_sb_c", 64'(sb_c), 64'h0000_8000_F001_1);
      idle_in(); commit_req = 1'b1; tick();
      commit_req = 1'b0;
      chk("t3_err_pulse", 64'(err_addr), 64'h0);
      chk("t3_nd_done", 64'(commit_done), 64'h1);
      chk("t3_nd_busy", 64'(busy), 64'h0);
      chk("t3_nd_sb_c", 64'(sb_c), 64'h0000_8000_F001_1);
      tick();
      chk("t3_nd_pulse", 64'(commit_done), 64'h0);

      // 4: requests during BREAK are ignored
      wr(6'd0, 12'h0AA); tick();
      idle_in(); commit_req = 1'b1; tick();
      wr(6'd0, 12'hFFF); clear_req = 1'b1;
      chk("t4_brk_ready", 64'(cfg_if.cfg_ready), 64'h0);
      chk("t4_brk1_sb_c", 64'(sb_c), 64'h0000_8000_F000_0);
      tick();
      idle_in();
      chk("t4_brk2_busy", 64'(busy), 64'h1);
      tick();
      chk("t4_live_sb_c", 64'(sb_c), 64'h0000_8000_F00A_A);
      chk("t4_live_done", 64'(commit_done), 64'h1);
      tick();
      commit_req = 1'b1; tick();
      commit_req = 1'b0;
      chk("t4_clean_done", 64'(commit_done), 64'h1);
      chk("t4_clean_busy", 64'(busy), 64'h0);

      // 5: reset during BREAK abandons the commit
      wr(6'd3, 12'h555); tick();
      idle_in(); commit_req = 1'b1; tick();
      commit_req = 1'b0;
      chk("t5_brk_busy", 64'(busy), 64'h1);
      rst_n = 1'b0; tick();
      chk("t5_rst_sb_c", 64'(sb_c), 64'h0);
      chk("t5_rst_busy", 64'(busy), 64'h0);
      chk("t5_rst_done", 64'(commit_done), 64'h0);
      rst_n = 1'b1; tick();
      chk("t5_post_done", 64'(commit_done), 64'h0);
      commit_req = 1'b1; tick();
      commit_req = 1'b0;
      chk("t5_nd_done", 64'(commit_done), 64'h1);
      chk("t5_nd_sb_c", 64'(sb_c), 64'h0);

      // 6: same-cycle write+commit, then clear beats a write
      wr(6'd3, 12'h00A); commit_req = 1'b1; tick();
      idle_in();
      chk("t6_brk_busy", 64'(busy), 64'h1);
      tick(); tick();
      chk("t6_live_sb_c", 64'(sb_c), 64'h00A0_0000_0000);
      chk("t6_live_done", 64'(commit_done), 64'h1);
      wr(6'd1, 12'hFFF); clear_req = 1'b1; tick();
      idle_in();
      chk("t6_clr_sb_c", 64'(sb_c), 64'h0);
      chk("t6_clr_done", 64'(commit_done), 64'h0);
      chk("t6_clr_busy", 64'(busy), 64'h0);
      commit_req = 1'b1; tick();
      commit_req = 1'b0;
      chk("t6_nd_done", 64'(commit_done), 64'h1);
      chk("t6_nd_busy", 64'(busy), 64'h0);
      chk("t6_nd_sb_c", 64'(sb_c), 64'h0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
